// File: rtl/ntt_pkg.sv
// Shared NTT arithmetic constants (modulus, Barrett factor, datapath widths) and the
// pointwise-multiplier state type; also used by ntt_engine and butterfly.
package ntt_pkg;

    localparam int unsigned COEF_W = 64;
    localparam int unsigned PROD_W = 62;
    localparam int unsigned RES_W  = 31;

    localparam logic [63:0] NTT_Q = 64'd1073750017;

    function automatic logic [63:0] barrett_mu(input logic [63:0] q);
        return (64'd1 << 60) / q;
    endfunction

    localparam logic [63:0] NTT_MU = barrett_mu(NTT_Q);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } pm_state_t;

endpackage

// File: rtl/barrett_reduce.sv
// Barrett reduction of a 62-bit product mod Q: quotient estimate + remainder, then final correction.
// Latency 2 cycles; both stages hold their contents while en is low.
module barrett_reduce
    import ntt_pkg::*;
#(
    parameter logic [63:0] Q = NTT_Q
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] p,
    output logic              out_valid,
    output logic [RES_W-1:0]  r
);

    localparam logic [63:0] MU = barrett_mu(Q);
    localparam logic [33:0] Q1 = 34'(Q);
    localparam logic [33:0] Q2 = 34'(Q << 1);

    logic [32:0] qhat;
    logic [33:0] rem;
    logic [33:0] s2_rem;
    logic        s2_vld;

    // qhat never exceeds the true quotient and trails it by at most two, so rem < 3Q.
    assign qhat = 33'((64'(p[PROD_W-1:29]) * MU) >> 31);
    assign rem  = 34'({2'b00, p} - 64'(qhat) * Q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld    <= 1'b0;
            s2_rem    <= '0;
            out_valid <= 1'b0;
            r         <= '0;
        end else if (en) begin
            s2_vld    <= in_valid;
            s2_rem    <= rem;
            out_valid <= s2_vld;
            if (s2_rem >= Q2) begin
                r <= RES_W'(s2_rem - Q2);
            end else if (s2_rem >= Q1) begin
                r <= RES_W'(s2_rem - Q1);
            end else begin
                r <= RES_W'(s2_rem);
            end
        end
    end

endmodule

// File: rtl/ntt_pointwise_mul.sv
// Pointwise (a*b) mod Q over one N-coefficient polynomial pair; 3-cycle latency, 1 result/cycle.
// An output stall (out_valid && !out_ready) freezes every stage and drops in_ready.
module ntt_pointwise_mul
    import ntt_pkg::*;
#(
    parameter int unsigned N_LOG = 12,
    parameter int unsigned N     = 4096,
    parameter logic [63:0] Q     = NTT_Q
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] a_in,
    input  logic [COEF_W-1:0] b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] c_out,
    output logic              busy,
    output logic              done,
    output logic              range_err
);

    localparam logic [N_LOG:0] N_CNT    = (N_LOG + 1)'(N);
    localparam logic [N_LOG:0] LAST_CNT = (N_LOG + 1)'(N - 1);

    pm_state_t         state, state_nxt;
    logic [N_LOG:0]    in_cnt, out_cnt;
    logic              advance, in_fire, out_fire, start_run;
    logic              a_bad, b_bad;
    logic [RES_W-1:0]  a_ok, b_ok, res;
    logic              s1_vld;
    logic [PROD_W-1:0] s1_prod;

    assign advance  = !out_valid || out_ready;
    assign in_ready = (state == ST_RUN) && (in_cnt < N_CNT) && advance;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign c_out    = COEF_W'(res);

    // Out-of-range operands enter the pipeline as zero.
    assign a_bad = (a_in >= Q);
    assign b_bad = (b_in >= Q);
    assign a_ok  = a_bad ? '0 : a_in[RES_W-1:0];
    assign b_ok  = b_bad ? '0 : b_in[RES_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (out_fire && (out_cnt == LAST_CNT)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            range_err <= 1'b0;
        end else if (start_run) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            range_err <= 1'b0;
        end else begin
            if (in_fire) begin
                in_cnt <= in_cnt + 1'b1;
                if (a_bad || b_bad) begin
                    range_err <= 1'b1;
                end
            end
            if (out_fire) begin
                out_cnt <= out_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_prod <= '0;
        end else if (advance) begin
            s1_vld <= in_fire;
            if (in_fire) begin
                s1_prod <= PROD_W'(a_ok) * PROD_W'(b_ok);
            end
        end
    end

    barrett_reduce #(
        .Q(Q)
    ) u_barrett (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (advance),
        .in_valid (s1_vld),
        .p        (s1_prod),
        .out_valid(out_valid),
        .r        (res)
    );

endmodule
